// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter.
//   arb_state_e      : arbiter FSM states
//   TIMEOUT_DATA_DEF : default response data returned when the slave times out
//   BHW_*            : byte/half/word access codes, shared with memory_top
//   rr_pick          : round-robin selection between the two pending masters
//   grant_of         : one-hot grant vector for a selected master
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;

  localparam logic [2:0] BHW_BYTE   = 3'b000;
  localparam logic [2:0] BHW_HALF   = 3'b001;
  localparam logic [2:0] BHW_WORD   = 3'b010;
  localparam logic [2:0] BHW_BYTE_U = 3'b100;
  localparam logic [2:0] BHW_HALF_U = 3'b101;

  // Returns the index of the master to serve. When both are pending the
  // round-robin pointer decides (0 favours m0, 1 favours m1).
  function automatic logic rr_pick(input logic pend0, input logic pend1, input logic rr);
    logic sel;
    if (pend0 && pend1) sel = rr;
    else                sel = pend1;
    return sel;
  endfunction

  function automatic logic [1:0] grant_of(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_req_capture.sv
// Per-master request capture for the bus arbiter.
// Latches a single-cycle request pulse together with its fields and holds it
// as "pending" until the arbiter clears it after the response cycle.
// A pulse arriving while a request is still pending is dropped and the
// sticky overrun flag is raised (cleared only by reset).
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_dv                     request pulse from the master
//   i_data/i_address/i_bhw/i_write_notread   request fields
//   i_clr                    clear pending (arbiter response cycle)
//   o_pending                request waiting to be served
//   o_data/o_address/o_bhw/o_write_notread   captured fields
//   o_overrun                sticky: a request was dropped
module bus_req_capture
  import bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_dv,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [2:0]        i_bhw,
  input  logic              i_write_notread,
  input  logic              i_clr,
  output logic              o_pending,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_address,
  output logic [2:0]        o_bhw,
  output logic              o_write_notread,
  output logic              o_overrun
);

  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        bhw_q, bhw_d;
  logic              wnr_q, wnr_d;
  logic              accept;

  // A pulse in the clearing cycle is accepted: set wins over clear.
  assign accept = i_dv && (!pending_q || i_clr);

  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    data_d    = data_q;
    addr_d    = addr_q;
    bhw_d     = bhw_q;
    wnr_d     = wnr_q;
    if (accept) begin
      pending_d = 1'b1;
      data_d    = i_data;
      addr_d    = i_address;
      bhw_d     = i_bhw;
      wnr_d     = i_write_notread;
    end else if (i_clr) begin
      pending_d = 1'b0;
    end
    if (i_dv && !accept) overrun_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
      bhw_q     <= '0;
      wnr_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      bhw_q     <= bhw_d;
      wnr_q     <= wnr_d;
    end
  end

  assign o_pending       = pending_q;
  assign o_data          = data_q;
  assign o_address       = addr_q;
  assign o_bhw           = bhw_q;
  assign o_write_notread = wnr_q;
  assign o_overrun       = overrun_q;

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master arbiter sharing the memory_top bus port between CPU_top (m0)
// and a secondary master (m1). One transaction at a time, round-robin when
// both masters are pending, with a response timeout so a hung slave cannot
// lock the bus.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_mX_* (X = 0,1)                  master request fields and pulse
//   o_mX_data/o_mX_DV/o_mX_timeout    response to master X
//   o_s_*                             request to the slave (o_s_DV pulse)
//   i_s_data/i_s_DV                   slave completion
//   o_grant                           one-hot current owner, 00 when idle
//   o_overrun                         sticky per-master dropped-request flags
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; pick a pending master and load o_s_*
// ST_ISSUE | o_s_DV high for one cycle; slave may already complete here
// ST_WAIT  | waiting for i_s_DV or for the timeout count
// ST_RESP  | o_mX_DV to the owner; clear its pending flag, flip rr
module bus_arbiter_2m
  import bus_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       TIMEOUT      = 1023,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(TIMEOUT_DATA_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_m0_data,
  input  logic [ADDR_W-1:0] i_m0_address,
  input  logic              i_m0_DV,
  input  logic [2:0]        i_m0_bhw,
  input  logic              i_m0_write_notread,
  output logic [DATA_W-1:0] o_m0_data,
  output logic              o_m0_DV,
  output logic              o_m0_timeout,
  input  logic [DATA_W-1:0] i_m1_data,
  input  logic [ADDR_W-1:0] i_m1_address,
  input  logic              i_m1_DV,
  input  logic [2:0]        i_m1_bhw,
  input  logic              i_m1_write_notread,
  output logic [DATA_W-1:0] o_m1_data,
  output logic              o_m1_DV,
  output logic              o_m1_timeout,
  output logic [DATA_W-1:0] o_s_data,
  output logic [ADDR_W-1:0] o_s_address,
  output logic [2:0]        o_s_bhw,
  output logic              o_s_write_notread,
  output logic              o_s_DV,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_DV,
  output logic [1:0]        o_grant,
  output logic [1:0]        o_overrun
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  logic [1:0]        pend;
  logic [1:0]        clr;
  logic [DATA_W-1:0] cap_data [2];
  logic [ADDR_W-1:0] cap_addr [2];
  logic [2:0]        cap_bhw  [2];
  logic              cap_wnr  [2];

  bus_req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cap_m0 (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_dv            (i_m0_DV),
    .i_data          (i_m0_data),
    .i_address       (i_m0_address),
    .i_bhw           (i_m0_bhw),
    .i_write_notread (i_m0_write_notread),
    .i_clr           (clr[0]),
    .o_pending       (pend[0]),
    .o_data          (cap_data[0]),
    .o_address       (cap_addr[0]),
    .o_bhw           (cap_bhw[0]),
    .o_write_notread (cap_wnr[0]),
    .o_overrun       (o_overrun[0])
  );

  bus_req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cap_m1 (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_dv            (i_m1_DV),
    .i_data          (i_m1_data),
    .i_address       (i_m1_address),
    .i_bhw           (i_m1_bhw),
    .i_write_notread (i_m1_write_notread),
    .i_clr           (clr[1]),
    .o_pending       (pend[1]),
    .o_data          (cap_data[1]),
    .o_address       (cap_addr[1]),
    .o_bhw           (cap_bhw[1]),
    .o_write_notread (cap_wnr[1]),
    .o_overrun       (o_overrun[1])
  );

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s_dv_q, s_dv_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [2:0]        s_bhw_q, s_bhw_d;
  logic              s_wnr_q, s_wnr_d;
  logic              m0_dv_q, m0_dv_d, m1_dv_q, m1_dv_d;
  logic              m0_to_q, m0_to_d, m1_to_q, m1_to_d;
  logic [DATA_W-1:0] m0_data_q, m0_data_d, m1_data_q, m1_data_d;

  logic              sel;
  logic              owner;
  logic              timeout_hit;
  logic              resp_fire;
  logic              resp_to;
  logic [DATA_W-1:0] resp_data;

  assign owner       = grant_q[1];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_CNT);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    s_dv_d    = 1'b0;
    s_data_d  = s_data_q;
    s_addr_d  = s_addr_q;
    s_bhw_d   = s_bhw_q;
    s_wnr_d   = s_wnr_q;
    resp_fire = 1'b0;
    resp_to   = 1'b0;
    resp_data = i_s_data;
    clr       = 2'b00;
    sel       = rr_pick(pend[0], pend[1], rr_q);

    case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          s_data_d = cap_data[sel];
          s_addr_d = cap_addr[sel];
          s_bhw_d  = cap_bhw[sel];
          s_wnr_d  = cap_wnr[sel];
          grant_d  = grant_of(sel);
          s_dv_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_s_DV) begin
          resp_fire = 1'b1;
          resp_data = i_s_data;
          state_d   = ST_RESP;
        end else if ((state_q == ST_WAIT) && timeout_hit) begin
          resp_fire = 1'b1;
          resp_data = TIMEOUT_DATA;
          resp_to   = 1'b1;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        clr     = grant_q;
        rr_d    = ~owner;
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Response pulses are registered so o_mX_DV lands in the RESP cycle.
    m0_dv_d   = resp_fire && !owner;
    m1_dv_d   = resp_fire &&  owner;
    m0_to_d   = resp_fire && !owner && resp_to;
    m1_to_d   = resp_fire &&  owner && resp_to;
    m0_data_d = (resp_fire && !owner) ? resp_data : m0_data_q;
    m1_data_d = (resp_fire &&  owner) ? resp_data : m1_data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      s_dv_q    <= 1'b0;
      s_data_q  <= '0;
      s_addr_q  <= '0;
      s_bhw_q   <= '0;
      s_wnr_q   <= 1'b0;
      m0_dv_q   <= 1'b0;
      m1_dv_q   <= 1'b0;
      m0_to_q   <= 1'b0;
      m1_to_q   <= 1'b0;
      m0_data_q <= '0;
      m1_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      s_dv_q    <= s_dv_d;
      s_data_q  <= s_data_d;
      s_addr_q  <= s_addr_d;
      s_bhw_q   <= s_bhw_d;
      s_wnr_q   <= s_wnr_d;
      m0_dv_q   <= m0_dv_d;
      m1_dv_q   <= m1_dv_d;
      m0_to_q   <= m0_to_d;
      m1_to_q   <= m1_to_d;
      m0_data_q <= m0_data_d;
      m1_data_q <= m1_data_d;
    end
  end

  assign o_grant           = grant_q;
  assign o_s_DV            = s_dv_q;
  assign o_s_data          = s_data_q;
  assign o_s_address       = s_addr_q;
  assign o_s_bhw           = s_bhw_q;
  assign o_s_write_notread = s_wnr_q;
  assign o_m0_DV           = m0_dv_q;
  assign o_m1_DV           = m1_dv_q;
  assign o_m0_timeout      = m0_to_q;
  assign o_m1_timeout      = m1_to_q;
  assign o_m0_data         = m0_data_q;
  assign o_m1_data         = m1_data_q;

endmodule
